// File: rtl/vec_scalar_regfile_sb.sv
// vec_scalar_regfile_sb
// Unified scalar + vector register file for the vector ASIP decode stage.
// One scalar bank and one vector bank share a select encoding
// (MSB 1 = scalar bank, MSB 0 = vector bank, low bits = register index).
// Vector writes are per-lane masked; scalar writes take lane 0 of dataIn.
// Reads are combinational with same-cycle write bypass. Scalar reads are
// replicated into every lane. A busy bit per register tracks outstanding
// long-latency producers and drives the issue stall.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   rSel1, rSel2          read selects
//   regWrEn, regToWrite   write enable / write select
//   laneMask              per-lane write enable (vector writes only)
//   dataIn                write data, lane 0 in the least significant bits
//   resvEn, resvSel       mark a register busy from the next edge on
//   operand1, operand2    read data
//   busy1, busy2          busy bit of the selected register (with bypass)
//   stall                 busy1 | busy2
module vec_scalar_regfile_sb #(
  parameter int registerSize  = 8,
  parameter int selectionBits = 3,
  parameter int vectorSize    = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [selectionBits:0]              rSel1,
  input  logic [selectionBits:0]              rSel2,
  input  logic                                regWrEn,
  input  logic [selectionBits:0]              regToWrite,
  input  logic [vectorSize-1:0]               laneMask,
  input  logic [vectorSize*registerSize-1:0]  dataIn,
  input  logic                                resvEn,
  input  logic [selectionBits:0]              resvSel,
  output logic [vectorSize*registerSize-1:0]  operand1,
  output logic [vectorSize*registerSize-1:0]  operand2,
  output logic                                busy1,
  output logic                                busy2,
  output logic                                stall
);

  localparam int RS   = registerSize;
  localparam int IW   = selectionBits;
  localparam int SW   = selectionBits + 1;
  localparam int DW   = vectorSize * registerSize;
  localparam int NREG = 2 ** selectionBits;

  logic [DW-1:0]   vreg_q [NREG];
  logic [DW-1:0]   vreg_d [NREG];
  logic [RS-1:0]   sreg_q [NREG];
  logic [RS-1:0]   sreg_d [NREG];
  logic [NREG-1:0] busy_v_q, busy_v_d;
  logic [NREG-1:0] busy_s_q, busy_s_d;

  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rv_idx;

  assign wr_idx = regToWrite[IW-1:0];
  assign rv_idx = resvSel[IW-1:0];

  // Per-lane merge: masked lanes from new data, the rest from the old value.
  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [vectorSize-1:0] m);
    lane_merge = old_v;
    for (int l = 0; l < vectorSize; l++) begin
      if (m[l]) lane_merge[l*RS +: RS] = new_v[l*RS +: RS];
    end
  endfunction

  // Read value as it will look after this cycle's write (bypass included).
  function automatic logic [DW-1:0] read_operand(input logic [SW-1:0] sel);
    logic [IW-1:0] idx;
    logic          hit;
    idx = sel[IW-1:0];
    hit = regWrEn && (regToWrite == sel);
    if (sel[SW-1]) begin
      read_operand = hit ? {vectorSize{dataIn[RS-1:0]}} : {vectorSize{sreg_q[idx]}};
    end else begin
      read_operand = hit ? lane_merge(vreg_q[idx], dataIn, laneMask) : vreg_q[idx];
    end
  endfunction

  // A same-cycle write clears the busy view; a same-cycle reservation only
  // shows up once it has been registered.
  function automatic logic read_busy(input logic [SW-1:0] sel);
    logic [IW-1:0] idx;
    idx = sel[IW-1:0];
    if (regWrEn && (regToWrite == sel)) read_busy = 1'b0;
    else read_busy = sel[SW-1] ? busy_s_q[idx] : busy_v_q[idx];
  endfunction

  always_comb begin
    operand1 = '0;
    operand2 = '0;
    busy1    = 1'b0;
    busy2    = 1'b0;
    if (!reset) begin
      operand1 = read_operand(rSel1);
      operand2 = read_operand(rSel2);
      busy1    = read_busy(rSel1);
      busy2    = read_busy(rSel2);
    end
  end

  assign stall = busy1 | busy2;

  // Next state. The reservation is applied after the write clear so that a
  // simultaneous reserve + write to one register leaves it busy.
  always_comb begin
    vreg_d   = vreg_q;
    sreg_d   = sreg_q;
    busy_v_d = busy_v_q;
    busy_s_d = busy_s_q;
    if (regWrEn) begin
      if (regToWrite[SW-1]) begin
        sreg_d[wr_idx]   = dataIn[RS-1:0];
        busy_s_d[wr_idx] = 1'b0;
      end else begin
        vreg_d[wr_idx]   = lane_merge(vreg_q[wr_idx], dataIn, laneMask);
        busy_v_d[wr_idx] = 1'b0;
      end
    end
    if (resvEn) begin
      if (resvSel[SW-1]) busy_s_d[rv_idx] = 1'b1;
      else               busy_v_d[rv_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        vreg_q[r] <= '0;
        sreg_q[r] <= '0;
      end
      busy_v_q <= '0;
      busy_s_q <= '0;
    end else begin
      vreg_q   <= vreg_d;
      sreg_q   <= sreg_d;
      busy_v_q <= busy_v_d;
      busy_s_q <= busy_s_d;
    end
  end

endmodule

// File: doc/vec_scalar_regfile_sb.md
# vec_scalar_regfile_sb

Parametrised unified register file for the vector ASIP decode stage: one scalar bank and one vector bank behind a shared register-select encoding, with per-lane masked vector writes, write-to-read bypass and a per-register scoreboard for long-latency producers. Scalar reads are broadcast to all lanes. It sits between decode (read ports, reservations) and write-back (write port), and drives the hazard stall to the issue logic.

## Interface
- registerSize, 8, bits per lane / scalar register
- selectionBits, 3, index bits; registerQuantity = 2**selectionBits per bank
- vectorSize, 4, lanes per vector register
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- rSel1, rSel2  in  selectionBits+1  read selects; MSB 1 = scalar bank, 0 = vector bank; low bits = index
- regWrEn  in  1  write enable
- regToWrite  in  selectionBits+1  write select, same encoding
- laneMask  in  vectorSize  per-lane write enable; vector writes only, ignored for scalar
- dataIn  in  vectorSize*registerSize  write data; scalar writes use lane 0
- resvEn  in  1  reserve (mark busy) the register in resvSel
- resvSel  in  selectionBits+1  register to reserve
- operand1, operand2  out  vectorSize*registerSize  read data
- busy1, busy2  out  1  scoreboard bit of rSel1 / rSel2 register
- stall  out  1  busy1 | busy2

## Operation
- Storage: registerQuantity scalar registers and registerQuantity vector registers; busy bit per register per bank (2*registerQuantity bits).
- Vector write (regWrEn, MSB 0): at rising edge, lane i of the register is updated from dataIn lane i only where laneMask[i]=1; other lanes hold. laneMask=0 is a legal no-op write, but still clears busy.
- Scalar write (regWrEn, MSB 1): register loads dataIn lane 0; laneMask ignored.
- Read: combinational. Vector select returns all lanes; scalar select returns the scalar replicated into every lane.
- Bypass: if regWrEn and regToWrite == rSelN in the same cycle, operandN returns post-write value: vector = per-lane merge of dataIn (mask=1) with stored lane (mask=0); scalar = dataIn lane 0 broadcast. Both ports bypass independently.
- Scoreboard: resvEn sets busy of resvSel at next edge; regWrEn clears busy of regToWrite at next edge.
- Simultaneous reserve and write to same register: busy ends set (new producer wins); data still written.
- Reserve and write to different registers: both take effect.
- busyN is combinational from stored bits and rSelN, with bypass: a same-cycle write to rSelN forces busyN=0 unless resvEn also targets that register in that cycle (then busyN=0 still, since the reservation only becomes visible next cycle).
- Scalar and vector registers with equal index are distinct (independent data and busy bits).

## Timing
- Write/reserve latency: 1 cycle (visible on registered state after the edge); bypass makes written data and busy clear visible in the same cycle.
- Read latency: 0 cycles.
- Reset: asynchronous assert clears every data register and busy bit immediately; while reset=1, operand1/operand2 = 0, busy1/busy2/stall = 0, writes and reservations are ignored. Deassertion is synchronous to clk by the surrounding design; first write accepted at the first edge with reset=0.
- Reset asserted mid-operation (busy bits set, write in flight) discards the pending write and all reservations.
- No index wrap: all selectionBits-bit indices are valid.

## Test plan
- Reset: preload V2 = {0x11,0x22,0x33,0x44}, S5 busy, assert reset -> operand1 (rSel1=V2) = 0 immediately, busy1=0, stall=0.
- Masked write: V1={1,2,3,4}, then write V1 dataIn={0xA0,0xB0,0xC0,0xD0}, laneMask=0b0101 -> next cycle V1 = {0xA0,2,0xC0,4} (lane 0 first).
- Scalar broadcast/bypass: write S3=0x7E with rSel2=S3 same cycle -> operand2={0x7E,0x7E,0x7E,0x7E} that cycle; next cycle with regWrEn=0 same value; V3 unchanged.
- Vector bypass merge: V6={9,9,9,9}, write dataIn={1,2,3,4} mask=0b1000 with rSel1=V6 -> operand1={9,9,9,4} in the write cycle.
- Scoreboard: resvEn on V4 -> next cycle rSel1=V4 gives busy1=1, stall=1; write V4 -> busy1=0 in write cycle and after; simultaneous resvEn+write on V4 -> busy1=1 the following cycle.
- Bank independence: reserve S2, read V2 -> busy=0; write V2 -> S2 remains busy and unchanged.
